// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: state encodings, the NOP used
// by flushed pipeline registers, and the per-stage control bundle.
package pipe_ctrl_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_FLUSH    = 2'd1;
    localparam logic [1:0] ST_WAIT_MDU = 2'd2;

    // addi x0, x0, 0 -- loaded by IF/ID and ID/EX when their flush is high
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic hold_pc;
        logic hold_if_id;
        logic hold_id_ex;
        logic flush_if_id;
        logic flush_id_ex;
    } stage_ctrl_t;

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// Watchdog for multi-cycle operations: counts enabled cycles since the last
// clear and flags when the count reaches TIMEOUT_CYCLES-1.
module pipe_ctrl_wdog #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_ZERO = {WD_W{1'b0}};
    localparam logic [WD_W-1:0] WD_ONE  = {{(WD_W-1){1'b0}}, 1'b1};

    logic [WD_W-1:0] count_r;

    // Cycle counter; saturates at the expiry value so it can never wrap back
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= WD_ZERO;
        end else if (clr) begin
            count_r <= WD_ZERO;
        end else if (en && (count_r != WD_LAST)) begin
            count_r <= count_r + WD_ONE;
        end
    end

    assign expire = (count_r == WD_LAST);

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: turns redirects, multi-cycle-unit requests and
// fetch waits into per-stage hold/flush controls and a registered PC redirect.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    input  logic        mdu_start_i,
    input  logic        mdu_done_i,
    input  logic        bus_hold_i,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic        hold_pc_o,
    output logic        hold_if_id_o,
    output logic        hold_id_ex_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        mdu_abort_o,
    output logic [1:0]  state_o
);

    localparam int unsigned      CNT_W    = $clog2(FLUSH_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             jump_en_r;
    logic [31:0]      jump_addr_r;
    logic             load_jump_s;
    logic             wd_clr_s;
    logic             wd_en_s;
    logic             wd_expire_s;
    logic             abort_s;
    stage_ctrl_t      ctrl_s;

    pipe_ctrl_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr_s),
        .en     (wd_en_s),
        .expire (wd_expire_s)
    );

    // Next-state, flush counter and per-stage control decode
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        ctrl_s      = stage_ctrl_t'(5'b0_0000);
        load_jump_s = 1'b0;
        wd_clr_s    = 1'b0;
        wd_en_s     = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (jump_en_i) begin
                    ctrl_s.flush_if_id = 1'b1;
                    ctrl_s.flush_id_ex = 1'b1;
                    load_jump_s        = 1'b1;
                    cnt_nxt_s          = CNT_LOAD;
                    state_nxt_s        = ST_FLUSH;
                end else if (mdu_start_i) begin
                    ctrl_s.hold_pc    = 1'b1;
                    ctrl_s.hold_if_id = 1'b1;
                    ctrl_s.hold_id_ex = 1'b1;
                    wd_clr_s          = 1'b1;
                    state_nxt_s       = ST_WAIT_MDU;
                end else if (bus_hold_i || hold_flag_i) begin
                    ctrl_s.hold_pc    = 1'b1;
                    ctrl_s.hold_if_id = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                ctrl_s.flush_if_id = 1'b1;
                ctrl_s.flush_id_ex = 1'b1;
                if (jump_en_i) begin
                    load_jump_s = 1'b1;
                    cnt_nxt_s   = CNT_LOAD;
                end else if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            ST_WAIT_MDU: begin
                // EX is frozen here, so redirects and front-end holds are ignored
                if (mdu_done_i) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    wd_en_s           = 1'b1;
                    ctrl_s.hold_pc    = 1'b1;
                    ctrl_s.hold_if_id = 1'b1;
                    if (wd_expire_s) begin
                        // abandon the op: ID/EX takes a NOP instead of holding
                        abort_s            = 1'b1;
                        ctrl_s.flush_id_ex = 1'b1;
                        state_nxt_s        = ST_RUN;
                    end else begin
                        ctrl_s.hold_id_ex = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, flush counter and registered redirect to the PC
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_RUN;
            cnt_r       <= CNT_ZERO;
            jump_en_r   <= 1'b0;
            jump_addr_r <= 32'h0000_0000;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            jump_en_r <= load_jump_s;
            if (load_jump_s) begin
                jump_addr_r <= jump_addr_i;
            end
        end
    end

    assign jump_en_o     = jump_en_r;
    assign jump_addr_o   = jump_addr_r;
    assign hold_pc_o     = ctrl_s.hold_pc;
    assign hold_if_id_o  = ctrl_s.hold_if_id;
    assign hold_id_ex_o  = ctrl_s.hold_id_ex;
    assign flush_if_id_o = ctrl_s.flush_if_id;
    assign flush_id_ex_o = ctrl_s.flush_id_ex;
    assign mdu_abort_o   = abort_s;
    assign state_o       = state_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a cycle-level reference model pushes expected
// outputs and redirect targets; a negedge monitor pops and compares.
module tb_pipe_ctrl;

    localparam int FLUSH_CYCLES   = 2;
    localparam int TIMEOUT_CYCLES = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = 32'h0000_0000;
    logic        hold_flag_i = 1'b0;
    logic        mdu_start_i = 1'b0;
    logic        mdu_done_i = 1'b0;
    logic        bus_hold_i = 1'b0;
    logic        jump_en_o;
    logic [31:0] jump_addr_o;
    logic        hold_pc_o, hold_if_id_o, hold_id_ex_o;
    logic        flush_if_id_o, flush_id_ex_o, mdu_abort_o;
    logic [1:0]  state_o;

    pipe_ctrl #(
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst),
        .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .hold_flag_i(hold_flag_i), .mdu_start_i(mdu_start_i),
        .mdu_done_i(mdu_done_i), .bus_hold_i(bus_hold_i),
        .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o),
        .hold_pc_o(hold_pc_o), .hold_if_id_o(hold_if_id_o),
        .hold_id_ex_o(hold_id_ex_o), .flush_if_id_o(flush_if_id_o),
        .flush_id_ex_o(flush_id_ex_o), .mdu_abort_o(mdu_abort_o),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    // vec = {state[1:0], jump_en, hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, abort}
    typedef struct packed {
        logic [8:0]  vec;
        logic [31:0] addr;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] jmp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cycle_no = 0;

    // Reference model: cycles of flushing still owed, and cycles spent waiting on the MDU
    int          flush_left = 0;
    int          mdu_wait = -1;
    logic        pulse_m = 1'b0;
    logic [31:0] addr_m = 32'h0000_0000;

    task automatic model_cycle(input logic r, input logic j, input logic [31:0] a,
                               input logic hf, input logic ms, input logic md, input logic bh);
        logic [1:0] st;
        logic hp, hi, he, fi, fe, ab, take;
        exp_t e;
        hp = 1'b0; hi = 1'b0; he = 1'b0; fi = 1'b0; fe = 1'b0; ab = 1'b0; take = 1'b0;
        if (flush_left > 0) begin
            st = 2'd1; fi = 1'b1; fe = 1'b1;
            if (j) take = 1'b1;
            else flush_left = flush_left - 1;
        end else if (mdu_wait >= 0) begin
            st = 2'd2;
            if (md) begin
                mdu_wait = -1;
            end else if (mdu_wait == TIMEOUT_CYCLES - 1) begin
                ab = 1'b1; fe = 1'b1; hp = 1'b1; hi = 1'b1; mdu_wait = -1;
            end else begin
                hp = 1'b1; hi = 1'b1; he = 1'b1; mdu_wait = mdu_wait + 1;
            end
        end else begin
            st = 2'd0;
            if (j) begin
                fi = 1'b1; fe = 1'b1; take = 1'b1;
            end else if (ms) begin
                hp = 1'b1; hi = 1'b1; he = 1'b1; mdu_wait = 0;
            end else if (bh || hf) begin
                hp = 1'b1; hi = 1'b1;
            end
        end
        e.vec  = {st, pulse_m, hp, hi, he, fi, fe, ab};
        e.addr = addr_m;
        e.cyc  = cycle_no;
        exp_q.push_back(e);
        if (take) begin
            flush_left = FLUSH_CYCLES;
            addr_m = a;
        end
        pulse_m = take;
        if (r) begin
            flush_left = 0; mdu_wait = -1; pulse_m = 1'b0; addr_m = 32'h0000_0000;
        end else if (take) begin
            jmp_q.push_back(a);
        end
    endtask

    task automatic drive(input logic r, input logic j, input logic [31:0] a,
                         input logic hf, input logic ms, input logic md, input logic bh);
        rst = r; jump_en_i = j; jump_addr_i = a;
        hold_flag_i = hf; mdu_start_i = ms; mdu_done_i = md; bus_hold_i = bh;
        model_cycle(r, j, a, hf, ms, md, bh);
        @(posedge clk);
        #1;
        cycle_no = cycle_no + 1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: per-cycle control vector plus redirect pulses against the target queue
    always @(negedge clk) begin
        exp_t        e;
        logic [8:0]  act;
        logic [31:0] want;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = {state_o, jump_en_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
                   flush_if_id_o, flush_id_ex_o, mdu_abort_o};
            checks = checks + 1;
            if (act !== e.vec) begin
                errors = errors + 1;
                $display("FAIL ctrl_vec cycle %0d: got %b required %b (st,jen,hp,hi,he,fi,fe,ab)",
                         e.cyc, act, e.vec);
            end
            checks = checks + 1;
            if (jump_addr_o !== e.addr) begin
                errors = errors + 1;
                $display("FAIL jump_addr cycle %0d: got %h required %h", e.cyc, jump_addr_o, e.addr);
            end
        end
        if (jump_en_o === 1'b1) begin
            checks = checks + 1;
            if (jmp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL redirect_pulse: unexpected jump_en_o with addr %h", jump_addr_o);
            end else begin
                want = jmp_q.pop_front();
                if (jump_addr_o !== want) begin
                    errors = errors + 1;
                    $display("FAIL redirect_target: got %h required %h", jump_addr_o, want);
                end
            end
        end
    end

    initial begin
        logic        r, j, hf, ms, md, bh;
        logic [31:0] a;
        @(posedge clk);
        #1;
        // reset state
        drive(1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        // single redirect
        drive(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);
        // redirect restarted from inside FLUSH
        drive(1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);
        // MDU completes after 5 cycles; redirect and bus hold ignored while waiting
        drive(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        drive(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
        // MDU never completes: watchdog abort
        drive(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(10);
        // redirect beats bus hold, then bus hold and hold_flag alone
        drive(1'b0, 1'b1, 32'h0000_0444, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        // reset the cycle after a redirect, and together with a redirect
        drive(1'b0, 1'b1, 32'h0000_0880, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        drive(1'b1, 1'b1, 32'h0000_0990, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            r  = ($urandom_range(63, 0) == 0);
            j  = ($urandom_range(7, 0) == 0);
            ms = ($urandom_range(9, 0) == 0);
            md = ($urandom_range(5, 0) == 0);
            bh = ($urandom_range(3, 0) == 0);
            hf = ($urandom_range(7, 0) == 0);
            a  = $urandom;
            drive(r, j, a, hf, ms, md, bh);
        end
        idle(2);
        @(negedge clk);
        #1;
        checks = checks + 1;
        if (exp_q.size() != 0 || jmp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d vectors and %0d redirects left, required 0 and 0",
                     exp_q.size(), jmp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the RV32I core. Sits between the execute stage, the PC/fetch unit and the IF/ID and ID/EX pipeline registers.
- Turns execute-stage redirects, multi-cycle-unit requests and fetch-bus waits into per-stage hold and flush controls.
- Registers the redirect target to the PC and runs a watchdog on multi-cycle operations.

Parameters:
- FLUSH_CYCLES, 2: bubble cycles inserted into IF/ID and ID/EX after a redirect (legal range 1..15).
- TIMEOUT_CYCLES, 64: maximum cycles spent in WAIT_MDU before forced abort (legal range 2..255).

Ports:
- clk  in  1  core clock
- rst  in  1  reset
- jump_en_i  in  1  redirect request from execute stage
- jump_addr_i  in  32  redirect target from execute stage
- hold_flag_i  in  1  one-cycle front-end hold request from execute stage
- mdu_start_i  in  1  multi-cycle op issued in EX this cycle
- mdu_done_i  in  1  multi-cycle op result valid
- bus_hold_i  in  1  instruction fetch not ready
- jump_en_o  out  1  registered PC redirect strobe
- jump_addr_o  out  32  registered PC redirect target
- hold_pc_o  out  1  freeze PC
- hold_if_id_o  out  1  freeze IF/ID register
- hold_id_ex_o  out  1  freeze ID/EX register
- flush_if_id_o  out  1  load NOP into IF/ID
- flush_id_ex_o  out  1  load NOP into ID/EX
- mdu_abort_o  out  1  one-cycle pulse on watchdog expiry
- state_o  out  2  current state, for debug

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state RUN, flush counter 0, watchdog 0. jump_en_o=0, jump_addr_o=0, mdu_abort_o=0; all hold and flush outputs 0.
- State encoding: RUN=0, FLUSH=1, WAIT_MDU=2; value 3 is unused and recovers to RUN.
- RUN, event priority: jump_en_i, then mdu_start_i, then bus_hold_i or hold_flag_i.
- RUN with jump_en_i=1:
  - flush_if_id_o and flush_id_ex_o assert combinationally in the same cycle.
  - Next edge: jump_addr_o <= jump_addr_i, jump_en_o <= 1 for exactly one cycle.
  - Counter loads FLUSH_CYCLES-1; state goes to FLUSH.
- RUN with mdu_start_i=1 (no jump): hold_pc_o, hold_if_id_o and hold_id_ex_o assert combinationally. Watchdog clears; state goes to WAIT_MDU.
- RUN with bus_hold_i or hold_flag_i only: hold_pc_o and hold_if_id_o assert combinationally; hold_id_ex_o stays 0; no state change.
- FLUSH:
  - Both flush outputs held at 1; hold outputs at 0.
  - Counter decrements each cycle. When the counter is 0, next state is RUN.
  - FLUSH_CYCLES=2 therefore gives exactly 3 flush cycles including the redirect cycle.
  - A jump_en_i arriving in FLUSH restarts the sequence: new target registered, jump_en_o pulses again, counter reloads.
- WAIT_MDU:
  - All three holds = 1 while mdu_done_i=0. Watchdog increments each cycle.
  - mdu_done_i=1: holds drop combinationally that cycle; next state RUN.
  - Watchdog reaches TIMEOUT_CYCLES-1 without done: mdu_abort_o pulses for 1 cycle, flush_id_ex_o=1 that cycle, next state RUN.
  - jump_en_i, bus_hold_i and hold_flag_i are ignored in this state, because EX is frozen.
- jump_en_o is never asserted in two consecutive cycles unless jump_en_i also repeats.
- Hold and flush are never both asserted on the same register in the same cycle.
- rst asserted in any state overrides everything at the next edge. A pending redirect is dropped, with no jump_en_o pulse.
- Widths: counters are sized by $clog2 of their parameter plus 1. jump_addr_o is passed through unmodified, with no alignment masking.

Decomposition:
- Shared package/defines: state encodings for RUN, FLUSH and WAIT_MDU. The NOP instruction constant 32'h0000_0013 belongs there too, for the pipeline registers consuming the flush outputs.
- One natural sub-module: pipe_ctrl_wdog, holding the watchdog counter with clear/enable/expire.
- The flush counter stays inline.

Test Plan:
- After reset, jump_en_i=1 with jump_addr_i=32'h0000_0100 for 1 cycle:
  - flush outputs = 1 for 3 cycles;
  - jump_en_o=1 with jump_addr_o=32'h100 exactly on cycle +1;
  - state returns to RUN on cycle +3.
- Second jump during FLUSH (target 32'h200 on cycle +1): jump_en_o pulses again with 32'h200; flush extends to 3 cycles after the second jump.
- mdu_start_i, then mdu_done_i 5 cycles later: all holds = 1 for 5 cycles, 0 in the done cycle; no flush; state returns to RUN.
- mdu_start_i with no done, TIMEOUT_CYCLES=8: mdu_abort_o pulses once with flush_id_ex_o=1 on the final WAIT_MDU cycle; holds are 0 the following cycle.
- jump_en_i and bus_hold_i both asserted in the same cycle in RUN: flush wins, hold_pc_o=0. bus_hold_i alone for 3 cycles gives hold_pc_o=hold_if_id_o=1 and hold_id_ex_o=0.
- rst asserted on the cycle after jump_en_i: jump_en_o=0 at the next edge, all outputs 0, state_o=0.
